// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle FETCH/EXECUTE/WRITEBACK/NEXT sequencer for the 8-bit CPU with a
// req/ack instruction fetch, end-of-program detection, start/restart and a retired counter.
module control_unit_mc #(
  parameter int unsigned OP_W       = 3,
  parameter int unsigned RA_W       = 2,
  parameter int unsigned PC_W       = 8,
  parameter int unsigned PC_LAST    = (2 ** PC_W) - 1,
  parameter int unsigned CNT_W      = 16,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         start_i,
  output logic                         imem_req_o,
  input  logic                         imem_ack_i,
  input  logic [OP_W+3*RA_W-1:0]       instr_i,
  input  logic                         instr_valid_i,
  output logic [OP_W-1:0]              opcode_o,
  output logic [RA_W-1:0]              ra1_o,
  output logic [RA_W-1:0]              ra2_o,
  output logic [RA_W-1:0]              wa_o,
  output logic                         we_o,
  output logic [PC_W-1:0]              pc_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             retired_o
);

  localparam int unsigned INSTR_W = OP_W + 3 * RA_W;
  localparam logic [PC_W-1:0] PcLast = PC_W'(PC_LAST);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExecute,
    StWriteback,
    StNext,
    StDone
  } state_e;

  localparam state_e StReset = AUTO_START ? StFetch : StIdle;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]     retired_q, retired_d;
  logic                 show_ir;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= StReset;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StFetch;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      StFetch: begin
        // Ack with instr_valid low is the end-of-program marker; nothing is latched.
        if (imem_ack_i) begin
          if (instr_valid_i) begin
            ir_d    = instr_i;
            state_d = StExecute;
          end else begin
            state_d = StDone;
          end
        end
      end
      StExecute: begin
        state_d = StWriteback;
      end
      StWriteback: begin
        if (retired_q != CntMax) begin
          retired_d = retired_q + CNT_W'(1);
        end
        state_d = StNext;
      end
      StNext: begin
        if (pc_q == PcLast) begin
          state_d = StDone;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StReset;
      end
    endcase
  end

  always_comb begin
    imem_req_o = 1'b0;
    we_o       = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    show_ir    = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req_o = 1'b1;
        busy_o     = 1'b1;
      end
      StExecute, StNext: begin
        busy_o  = 1'b1;
        show_ir = 1'b1;
      end
      StWriteback: begin
        busy_o  = 1'b1;
        show_ir = 1'b1;
        we_o    = 1'b1;
      end
      StDone: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign opcode_o  = show_ir ? ir_q[INSTR_W-1 -: OP_W] : '0;
  assign ra1_o     = show_ir ? ir_q[3*RA_W-1 -: RA_W]  : '0;
  assign ra2_o     = show_ir ? ir_q[2*RA_W-1 -: RA_W]  : '0;
  assign wa_o      = show_ir ? ir_q[RA_W-1:0]          : '0;
  assign pc_o      = pc_q;
  assign retired_o = retired_q;

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Parameterised multi-cycle control unit for the 8-bit CPU, the successor to the fixed 9-bit-instruction sequencer. It sequences FETCH/EXECUTE/WRITEBACK/NEXT through a configurable instruction format. It adds a request/acknowledge instruction-memory handshake with wait states, explicit end-of-program detection through `instr_valid`, a programmable last address, start/restart control and a retired-instruction counter. It drives the ALU opcode, the RegFile addresses and write enable, and the instruction-memory PC.

## Interface
- `OP_W`, 3: ALU opcode width.
- `RA_W`, 2: register address width; instruction width is `INSTR_W = OP_W + 3*RA_W`.
- `PC_W`, 8: program counter width.
- `PC_LAST`, 2^PC_W-1: address of the last instruction; the PC never increments past it.
- `CNT_W`, 16: retired-instruction counter width.
- `AUTO_START`, 1: 1 means the block leaves reset directly into FETCH; 0 means it waits in IDLE for `start`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle pulse; starts from IDLE or restarts from DONE; ignored in all other states.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: instruction memory has `instr`/`instr_valid` ready this cycle.
- `instr` in INSTR_W: instruction word, fields {opcode, ra1, ra2, wa} from MSB to LSB.
- `instr_valid` in 1: 0 together with `imem_ack` marks end of program.
- `opcode` out OP_W: ALU operation.
- `ra1`, `ra2`, `wa` out RA_W: read and write register addresses.
- `we` out 1: RegFile write enable.
- `pc` out PC_W: instruction address.
- `busy` out 1: state is FETCH, EXECUTE, WRITEBACK or NEXT.
- `done` out 1: state is DONE.
- `retired` out CNT_W: count of completed WRITEBACKs.

## Operation
- **States:** IDLE, FETCH, EXECUTE, WRITEBACK, NEXT, DONE. The state, `pc`, the instruction register `ir` and `retired` are the only registers.
- **Reset** (`reset`=0 at a clock edge): state goes to FETCH if AUTO_START=1, else IDLE. `pc`=0, `ir`=0, `retired`=0. Reset overrides every other event, including mid-instruction.
- **IDLE:** on `start`=1, go to FETCH with `pc`=0 and `retired`=0.
- **FETCH:**
  - `imem_req`=1.
  - `imem_ack`=0: stay in FETCH; unlimited wait states.
  - `imem_ack`=1 and `instr_valid`=1: `ir`<=`instr`, go to EXECUTE.
  - `imem_ack`=1 and `instr_valid`=0: go to DONE; `ir`, `pc` and `retired` are unchanged.
- **EXECUTE:** go to WRITEBACK.
- **WRITEBACK:** `we`=1; `retired`<=`retired`+1, saturating at 2^CNT_W-1; go to NEXT.
- **NEXT:** if `pc`==PC_LAST, go to DONE with `pc` held. Otherwise `pc`<=`pc`+1 and go to FETCH. The PC never wraps.
- **DONE:** holds until `start`=1, which sets `pc`=0 and `retired`=0 and goes to FETCH.
- **Decoded outputs:** `opcode`/`ra1`/`ra2`/`wa` equal the `ir` fields in EXECUTE, WRITEBACK and NEXT, and are all zero in IDLE, FETCH and DONE.
- **Output decoding:** `we`, `imem_req`, `busy` and `done` are decoded from the state register only. No output depends combinationally on `instr`, `imem_ack` or `start`.

## Timing
- **Output values after a reset edge:** `pc`=0, `opcode`/`ra1`/`ra2`/`wa`=0, `we`=0, `done`=0, `retired`=0, `busy`=`imem_req`=AUTO_START.
- **Zero-wait throughput:** 4 cycles per instruction (FETCH, EXECUTE, WRITEBACK, NEXT). Each FETCH wait state adds 1 cycle.
- **Fetch handshake:** `pc` is stable for the whole time `imem_req`=1. `imem_ack` is sampled only in FETCH; an ack in any other state is ignored.
- **Write:** `we` is high for exactly one cycle per executed instruction. The `wa`/`opcode` values are stable across the preceding EXECUTE cycle and the WRITEBACK cycle.
- **Start:** `start` and `reset`=0 in the same cycle: reset wins. `start` while `busy`=1: ignored.
- **Last address:** with PC_LAST executed, `done` rises in the cycle after that instruction's NEXT cycle, and `pc` still equals PC_LAST.

## Test plan
- **Basic run.** Defaults, `imem_ack` tied high, `instr_valid`=1 at addresses 0..2 and 0 at address 3, instr[0]=9'b001_01_10_11.
  - EXECUTE shows opcode=1, ra1=1, ra2=2, wa=3.
  - One `we` pulse per instruction.
  - `done`=1 with `pc`=3 and `retired`=3, reached 13 cycles after reset release.
- **Wait states.** `imem_ack` delayed 2 cycles on every fetch, 2 valid instructions.
  - 6 cycles per instruction.
  - `pc` constant while `imem_req`=1.
  - `retired`=2.
- **Last address.** PC_LAST=4, all instructions valid.
  - Exactly 5 `we` pulses.
  - `done`=1 with `pc`=4; no fetch of address 5.
- **Start control.** AUTO_START=0.
  - Block stays in IDLE for 10 cycles with `imem_req`=0.
  - `start` pulse gives FETCH at `pc`=0 the next cycle.
  - `start` pulse during run has no effect.
  - After DONE, `start` resets `pc`/`retired` to 0 and reruns.
- **Reset mid-operation.** `reset`=0 asserted in WRITEBACK.
  - Next edge: `we`=0, `pc`=0, `retired`=0, state FETCH.
  - The interrupted instruction is not counted.
- **Counter saturation.** CNT_W=2, 6 valid instructions.
  - `retired` sticks at 3.
  - All 6 `we` pulses still occur.
